teak_action_fill_gmem: RTL and testbench

Parametrised kernel action that replaces the tied-off stub action with a working memory-fill engine. On a go token it fetches four parameter words through the parameter SELF channels, then writes an incrementing pattern to global memory over the AXI master write channels in 4 KB-safe INCR bursts, and finally issues a done token. It sits in the same toplevel slot as the single-gmem action and keeps the same go/done and parameter channel contract; the AXI slave control port is not part of this block.

---
 rtl/teak_action_fill_gmem.sv | 258 +++++++++++++++++++++++++
 tb/tb_teak_action_fill_gmem.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/teak_action_fill_gmem.sv
// Memory-fill kernel action: fetches base/count/pattern over the parameter channels, then
// writes an incrementing 32-bit pattern to gmem in 4 KB-safe INCR bursts and returns done.
module teak_action_fill_gmem #(
   parameter int          ADDR_WIDTH = 64,
   parameter int          DATA_WIDTH = 32,
   parameter int          ID_WIDTH   = 1,
   parameter int          USER_WIDTH = 1,
   parameter int          MAX_BURST  = 16,
   parameter logic [31:0] PARAM_BASE = 32'h0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      go_0Ready,
   output logic                      go_0Stop,
   output logic                      done_0Ready,
   input  logic                      done_0Stop,
   output logic                      paramaddr_0Ready,
   output logic [31:0]               paramaddr_0Data,
   input  logic                      paramaddr_0Stop,
   input  logic                      paramdata_0Ready,
   input  logic [31:0]               paramdata_0Data,
   output logic                      paramdata_0Stop,
   output logic                      m_axi_gmem_awvalid,
   input  logic                      m_axi_gmem_awready,
   output logic [ADDR_WIDTH-1:0]     m_axi_gmem_awaddr,
   output logic [ID_WIDTH-1:0]       m_axi_gmem_awid,
   output logic [7:0]                m_axi_gmem_awlen,
   output logic [2:0]                m_axi_gmem_awsize,
   output logic [1:0]                m_axi_gmem_awburst,
   output logic                      m_axi_gmem_awlock,
   output logic [3:0]                m_axi_gmem_awcache,
   output logic [2:0]                m_axi_gmem_awprot,
   output logic [3:0]                m_axi_gmem_awqos,
   output logic [3:0]                m_axi_gmem_awregion,
   output logic [USER_WIDTH-1:0]     m_axi_gmem_awuser,
   output logic                      m_axi_gmem_wvalid,
   input  logic                      m_axi_gmem_wready,
   output logic [DATA_WIDTH-1:0]     m_axi_gmem_wdata,
   output logic [DATA_WIDTH/8-1:0]   m_axi_gmem_wstrb,
   output logic                      m_axi_gmem_wlast,
   output logic [USER_WIDTH-1:0]     m_axi_gmem_wuser,
   input  logic                      m_axi_gmem_bvalid,
   output logic                      m_axi_gmem_bready,
   input  logic [1:0]                m_axi_gmem_bresp,
   input  logic [ID_WIDTH-1:0]       m_axi_gmem_bid,
   input  logic [USER_WIDTH-1:0]     m_axi_gmem_buser,
   output logic                      m_axi_gmem_arvalid,
   input  logic                      m_axi_gmem_arready,
   output logic [ADDR_WIDTH-1:0]     m_axi_gmem_araddr,
   output logic [ID_WIDTH-1:0]       m_axi_gmem_arid,
   output logic [7:0]                m_axi_gmem_arlen,
   output logic [2:0]                m_axi_gmem_arsize,
   output logic [1:0]                m_axi_gmem_arburst,
   output logic                      m_axi_gmem_arlock,
   output logic [3:0]                m_axi_gmem_arcache,
   output logic [2:0]                m_axi_gmem_arprot,
   output logic [3:0]                m_axi_gmem_arqos,
   output logic [3:0]                m_axi_gmem_arregion,
   output logic [USER_WIDTH-1:0]     m_axi_gmem_aruser,
   input  logic                      m_axi_gmem_rvalid,
   output logic                      m_axi_gmem_rready,
   input  logic [DATA_WIDTH-1:0]     m_axi_gmem_rdata,
   input  logic [1:0]                m_axi_gmem_rresp,
   input  logic                      m_axi_gmem_rlast,
   input  logic [ID_WIDTH-1:0]       m_axi_gmem_rid,
   input  logic [USER_WIDTH-1:0]     m_axi_gmem_ruser
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int LOG2B = $clog2(BYTES);
   localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(BYTES - 1);

   // state  | meaning
   // IDLE   | waiting for go
   // P_REQ  | presenting parameter address idx
   // P_WAIT | waiting for parameter word idx
   // AW     | burst address valid
   // W      | streaming burst beats
   // B      | waiting for write response
   // DONE   | presenting done token
   localparam logic [2:0] S_IDLE = 3'd0, S_P_REQ = 3'd1, S_P_WAIT = 3'd2, S_AW = 3'd3,
                          S_W = 3'd4, S_B = 3'd5, S_DONE = 3'd6;

   logic [2:0]            state_q, state_d;
   logic [1:0]            idx_q, idx_d;
   logic [31:0]           base_lo_q, base_lo_d, base_hi_q, base_hi_d, count_q, count_d;
   logic [31:0]           word_q, word_d, rem_q, rem_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            awlen_q, awlen_d;
   logic [8:0]            beats_q, beats_d, beat_q, beat_d;
   logic                  wlast_q, wlast_d;

   logic [63:0]           base_full;
   logic [ADDR_WIDTH-1:0] addr_nx;
   logic [31:0]           rem_nx, lim_burst, words_4k, beats_nx;
   logic [12:0]           bytes_4k;

   // Next burst is sized from the values about to be loaded: the fresh base after the
   // last parameter word, or the advanced address/remaining after a good response.
   always_comb begin
      base_full = {base_hi_q, base_lo_q};
      addr_nx   = (state_q == S_B) ? addr_q + (ADDR_WIDTH'(beats_q) << LOG2B)
                                   : base_full[ADDR_WIDTH-1:0] & ~LOW_MASK;
      rem_nx    = (state_q == S_B) ? rem_q - 32'(beats_q) : count_q;
      bytes_4k  = 13'h1000 - {1'b0, addr_nx[11:0]};
      words_4k  = 32'(bytes_4k >> LOG2B);
      lim_burst = (rem_nx < 32'(MAX_BURST)) ? rem_nx : 32'(MAX_BURST);
      beats_nx  = (lim_burst < words_4k) ? lim_burst : words_4k;
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      base_lo_d = base_lo_q;
      base_hi_d = base_hi_q;
      count_d   = count_q;
      word_d    = word_q;
      rem_d     = rem_q;
      addr_d    = addr_q;
      awlen_d   = awlen_q;
      beats_d   = beats_q;
      beat_d    = beat_q;
      wlast_d   = wlast_q;
      case (state_q)
         S_IDLE: if (go_0Ready) begin
            idx_d   = 2'd0;
            state_d = S_P_REQ;
         end
         S_P_REQ: if (!paramaddr_0Stop) state_d = S_P_WAIT;
         S_P_WAIT: if (paramdata_0Ready) begin
            case (idx_q)
               2'd0:    base_lo_d = paramdata_0Data;
               2'd1:    base_hi_d = paramdata_0Data;
               2'd2:    count_d   = paramdata_0Data;
               default: word_d    = paramdata_0Data;
            endcase
            if (idx_q == 2'd3) begin
               addr_d = addr_nx;
               rem_d  = rem_nx;
               if (count_q == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_AW;
                  awlen_d = 8'(beats_nx - 32'd1);
                  beats_d = 9'(beats_nx);
               end
            end else begin
               idx_d   = idx_q + 2'd1;
               state_d = S_P_REQ;
            end
         end
         S_AW: if (m_axi_gmem_awready) begin
            state_d = S_W;
            beat_d  = '0;
            wlast_d = (beats_q == 9'd1);
         end
         S_W: if (m_axi_gmem_wready) begin
            word_d  = word_q + 32'd1;
            beat_d  = beat_q + 9'd1;
            wlast_d = (beat_q + 9'd2 == beats_q);
            if (wlast_q) begin
               state_d = S_B;
               wlast_d = 1'b0;
            end
         end
         S_B: if (m_axi_gmem_bvalid) begin
            if (m_axi_gmem_bresp != 2'b00) begin
               state_d = S_DONE;
            end else begin
               addr_d = addr_nx;
               rem_d  = rem_nx;
               if (rem_nx == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_AW;
                  awlen_d = 8'(beats_nx - 32'd1);
                  beats_d = 9'(beats_nx);
               end
            end
         end
         S_DONE: if (!done_0Stop) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         base_lo_q <= '0;
         base_hi_q <= '0;
         count_q   <= '0;
         word_q    <= '0;
         rem_q     <= '0;
         addr_q    <= '0;
         awlen_q   <= '0;
         beats_q   <= '0;
         beat_q    <= '0;
         wlast_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         base_lo_q <= base_lo_d;
         base_hi_q <= base_hi_d;
         count_q   <= count_d;
         word_q    <= word_d;
         rem_q     <= rem_d;
         addr_q    <= addr_d;
         awlen_q   <= awlen_d;
         beats_q   <= beats_d;
         beat_q    <= beat_d;
         wlast_q   <= wlast_d;
      end
   end

   assign go_0Stop            = (state_q != S_IDLE);
   assign done_0Ready         = (state_q == S_DONE);
   assign paramaddr_0Ready    = (state_q == S_P_REQ);
   assign paramaddr_0Data     = (state_q == S_P_REQ) ? PARAM_BASE + {28'd0, idx_q, 2'b00} : 32'd0;
   assign paramdata_0Stop     = (state_q != S_P_WAIT);

   assign m_axi_gmem_awvalid  = (state_q == S_AW);
   assign m_axi_gmem_awaddr   = addr_q;
   assign m_axi_gmem_awid     = '0;
   assign m_axi_gmem_awlen    = awlen_q;
   assign m_axi_gmem_awsize   = 3'(LOG2B);
   assign m_axi_gmem_awburst  = 2'b01;
   assign m_axi_gmem_awlock   = 1'b0;
   assign m_axi_gmem_awcache  = 4'b0011;
   assign m_axi_gmem_awprot   = '0;
   assign m_axi_gmem_awqos    = '0;
   assign m_axi_gmem_awregion = '0;
   assign m_axi_gmem_awuser   = '0;
   assign m_axi_gmem_wvalid   = (state_q == S_W);
   assign m_axi_gmem_wdata    = DATA_WIDTH'(word_q);
   assign m_axi_gmem_wstrb    = '1;
   assign m_axi_gmem_wlast    = wlast_q;
   assign m_axi_gmem_wuser    = '0;
   assign m_axi_gmem_bready   = (state_q == S_B);

   assign m_axi_gmem_arvalid  = 1'b0;
   assign m_axi_gmem_araddr   = '0;
   assign m_axi_gmem_arid     = '0;
   assign m_axi_gmem_arlen    = '0;
   assign m_axi_gmem_arsize   = '0;
   assign m_axi_gmem_arburst  = '0;
   assign m_axi_gmem_arlock   = 1'b0;
   assign m_axi_gmem_arcache  = '0;
   assign m_axi_gmem_arprot   = '0;
   assign m_axi_gmem_arqos    = '0;
   assign m_axi_gmem_arregion = '0;
   assign m_axi_gmem_aruser   = '0;
   assign m_axi_gmem_rready   = 1'b0;

   logic unused_ok;
   assign unused_ok = ^{m_axi_gmem_bid, m_axi_gmem_buser, m_axi_gmem_arready, m_axi_gmem_rvalid,
                        m_axi_gmem_rdata, m_axi_gmem_rresp, m_axi_gmem_rlast, m_axi_gmem_rid,
                        m_axi_gmem_ruser};
endmodule

// File: tb/tb_teak_action_fill_gmem.sv
// Directed bench for teak_action_fill_gmem: a bench-side parameter/AXI responder logs every
// handshake, and each test task compares the logs against hand-computed expectations.
module tb_teak_action_fill_gmem;
   logic        clk = 1'b0;
   logic        reset;
   logic        go_0Ready, go_0Stop, done_0Ready, done_0Stop;
   logic        paramaddr_0Ready, paramaddr_0Stop, paramdata_0Ready, paramdata_0Stop;
   logic [31:0] paramaddr_0Data, paramdata_0Data;
   logic        awvalid, awready, awlock, wvalid, wready, wlast, bvalid, bready;
   logic [63:0] awaddr, araddr;
   logic [0:0]  awid, awuser, wuser, bid, buser, arid, aruser, rid, ruser;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, awprot, arsize, arprot;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic [3:0]  awcache, awqos, awregion, arcache, arqos, arregion, wstrb;
   logic [31:0] wdata, rdata;
   logic        arvalid, arready, arlock, rvalid, rready, rlast;

   teak_action_fill_gmem dut (
      .clk(clk), .reset(reset),
      .go_0Ready(go_0Ready), .go_0Stop(go_0Stop),
      .done_0Ready(done_0Ready), .done_0Stop(done_0Stop),
      .paramaddr_0Ready(paramaddr_0Ready), .paramaddr_0Data(paramaddr_0Data),
      .paramaddr_0Stop(paramaddr_0Stop),
      .paramdata_0Ready(paramdata_0Ready), .paramdata_0Data(paramdata_0Data),
      .paramdata_0Stop(paramdata_0Stop),
      .m_axi_gmem_awvalid(awvalid), .m_axi_gmem_awready(awready), .m_axi_gmem_awaddr(awaddr),
      .m_axi_gmem_awid(awid), .m_axi_gmem_awlen(awlen), .m_axi_gmem_awsize(awsize),
      .m_axi_gmem_awburst(awburst), .m_axi_gmem_awlock(awlock), .m_axi_gmem_awcache(awcache),
      .m_axi_gmem_awprot(awprot), .m_axi_gmem_awqos(awqos), .m_axi_gmem_awregion(awregion),
      .m_axi_gmem_awuser(awuser),
      .m_axi_gmem_wvalid(wvalid), .m_axi_gmem_wready(wready), .m_axi_gmem_wdata(wdata),
      .m_axi_gmem_wstrb(wstrb), .m_axi_gmem_wlast(wlast), .m_axi_gmem_wuser(wuser),
      .m_axi_gmem_bvalid(bvalid), .m_axi_gmem_bready(bready), .m_axi_gmem_bresp(bresp),
      .m_axi_gmem_bid(bid), .m_axi_gmem_buser(buser),
      .m_axi_gmem_arvalid(arvalid), .m_axi_gmem_arready(arready), .m_axi_gmem_araddr(araddr),
      .m_axi_gmem_arid(arid), .m_axi_gmem_arlen(arlen), .m_axi_gmem_arsize(arsize),
      .m_axi_gmem_arburst(arburst), .m_axi_gmem_arlock(arlock), .m_axi_gmem_arcache(arcache),
      .m_axi_gmem_arprot(arprot), .m_axi_gmem_arqos(arqos), .m_axi_gmem_arregion(arregion),
      .m_axi_gmem_aruser(aruser),
      .m_axi_gmem_rvalid(rvalid), .m_axi_gmem_rready(rready), .m_axi_gmem_rdata(rdata),
      .m_axi_gmem_rresp(rresp), .m_axi_gmem_rlast(rlast), .m_axi_gmem_rid(rid),
      .m_axi_gmem_ruser(ruser)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] prm [4];
   bit          stall_en = 0;
   bit          err_first = 0;
   int          cyc = 0;
   int          go_cyc = 0;
   int          aw_first = -1;
   int          done_cnt = 0;
   int          b_cnt = 0;
   int          stab_err = 0;
   int          gostop_err = 0;
   bit          pend_v = 0;
   logic [1:0]  pend_idx = '0;
   bit          b_pend = 0;
   bit          busy = 0;
   bit          aw_hold = 0;
   bit          w_hold = 0;
   logic [63:0] h_awaddr;
   logic [7:0]  h_awlen;
   logic [31:0] h_wdata;
   logic        h_wlast;
   logic [31:0] preq_q [$];
   logic [63:0] aw_addr_q [$];
   logic [7:0]  aw_len_q [$];
   logic [31:0] w_data_q [$];
   logic        w_last_q [$];

   // Responder: drive inputs on the falling edge, sample handshakes 1 ns before the rising edge.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         paramaddr_0Stop  = stall_en && ($urandom_range(0, 2) == 0);
         paramdata_0Ready = pend_v && !(stall_en && ($urandom_range(0, 2) == 0));
         paramdata_0Data  = paramdata_0Ready ? prm[pend_idx] : 32'h0;
         awready          = !(stall_en && ($urandom_range(0, 1) == 0));
         wready           = !(stall_en && ($urandom_range(0, 1) == 0));
         bvalid           = b_pend && !(stall_en && ($urandom_range(0, 2) == 0));
         bresp            = (err_first && b_cnt == 0) ? 2'b10 : 2'b00;
         done_0Stop       = stall_en && ($urandom_range(0, 1) == 0);
         #4;
         if (reset) begin
            pend_v = 0; b_pend = 0; busy = 0; aw_hold = 0; w_hold = 0;
         end else begin
            if (aw_hold && (!awvalid || awaddr !== h_awaddr || awlen !== h_awlen)) stab_err++;
            aw_hold = awvalid && !awready;
            h_awaddr = awaddr; h_awlen = awlen;
            if (w_hold && (!wvalid || wdata !== h_wdata || wlast !== h_wlast)) stab_err++;
            w_hold = wvalid && !wready;
            h_wdata = wdata; h_wlast = wlast;
            if (busy && go_0Stop !== 1'b1) gostop_err++;
            if (go_0Ready && !go_0Stop) begin busy = 1; go_cyc = cyc; end
            if (paramdata_0Ready && !paramdata_0Stop) pend_v = 0;
            if (paramaddr_0Ready && !paramaddr_0Stop) begin
               pend_v = 1; pend_idx = paramaddr_0Data[3:2]; preq_q.push_back(paramaddr_0Data);
            end
            if (awvalid && aw_first < 0) aw_first = cyc;
            if (awvalid && awready) begin aw_addr_q.push_back(awaddr); aw_len_q.push_back(awlen); end
            if (wvalid && wready) begin
               w_data_q.push_back(wdata); w_last_q.push_back(wlast);
               if (wlast) b_pend = 1;
            end
            if (bvalid && bready) begin b_pend = 0; b_cnt++; end
            if (done_0Ready && !done_0Stop) begin done_cnt++; busy = 0; end
         end
      end
   end

   task automatic clear_logs();
      preq_q.delete(); aw_addr_q.delete(); aw_len_q.delete(); w_data_q.delete(); w_last_q.delete();
      done_cnt = 0; b_cnt = 0; stab_err = 0; gostop_err = 0; aw_first = -1;
   endtask

   task automatic start_fill(input logic [31:0] lo, input logic [31:0] hi,
                             input logic [31:0] cnt, input logic [31:0] pat);
      prm[0] = lo; prm[1] = hi; prm[2] = cnt; prm[3] = pat;
      clear_logs();
      @(negedge clk); go_0Ready = 1;
      @(posedge clk); #1 go_0Ready = 0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (done_cnt == 0 && n < 3000) begin @(negedge clk); n++; end
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({go_0Stop, done_0Ready, paramaddr_0Ready, paramdata_0Stop, awvalid, wvalid, wlast, bready}
          !== 8'b0001_0000) begin
         n_bad++; $display("FAIL reset_ctl: got %b want 00010000",
            {go_0Stop, done_0Ready, paramaddr_0Ready, paramdata_0Stop, awvalid, wvalid, wlast, bready});
      end
      n_cmp++;
      if (awaddr !== 64'h0) begin n_bad++; $display("FAIL reset_awaddr: got %h want 0", awaddr); end
      n_cmp++;
      if (wdata !== 32'h0) begin n_bad++; $display("FAIL reset_wdata: got %h want 0", wdata); end
      n_cmp++;
      if (paramaddr_0Data !== 32'h0) begin
         n_bad++; $display("FAIL reset_paramaddr: got %h want 0", paramaddr_0Data);
      end
      n_cmp++;
      if (awlen !== 8'h0) begin n_bad++; $display("FAIL reset_awlen: got %h want 0", awlen); end
      n_cmp++;
      if ({awsize, awburst, awcache, wstrb} !== {3'd2, 2'd1, 4'd3, 4'hF}) begin
         n_bad++; $display("FAIL reset_attrs: got %h want %h", {awsize, awburst, awcache, wstrb},
                           {3'd2, 2'd1, 4'd3, 4'hF});
      end
      n_cmp++;
      if ({awid, awuser, awlock, awqos, awregion, awprot, wuser, araddr, arid, arlen, arsize, arburst,
           arlock, arcache, arprot, arqos, arregion, aruser, rready, arvalid} !== '0) begin
         n_bad++; $display("FAIL reset_tieoffs: nonzero tied-off output");
      end
      @(negedge clk); reset = 0;
   endtask

   task automatic test_fill_basic();
      start_fill(32'h1000, 32'h0, 32'd5, 32'hA0);
      wait_done();
      n_cmp++;
      if (done_cnt !== 1) begin n_bad++; $display("FAIL fill_done: got %0d want 1", done_cnt); end
      n_cmp++;
      if (preq_q.size() != 4 || preq_q[0] !== 0 || preq_q[1] !== 4 || preq_q[2] !== 8 || preq_q[3] !== 12) begin
         n_bad++; $display("FAIL fill_param_addrs: got %p want 0,4,8,12", preq_q);
      end
      n_cmp++;
      if (aw_addr_q.size() != 1 || aw_addr_q[0] !== 64'h1000 || aw_len_q[0] !== 8'd4) begin
         n_bad++; $display("FAIL fill_aw: got %p/%p want 1000/4", aw_addr_q, aw_len_q);
      end
      n_cmp++;
      if (aw_first - go_cyc - 1 !== 8) begin
         n_bad++; $display("FAIL fill_latency: got %0d want 8", aw_first - go_cyc - 1);
      end
      n_cmp++;
      if (b_cnt !== 1) begin n_bad++; $display("FAIL fill_bcount: got %0d want 1", b_cnt); end
      n_cmp++;
      if (w_data_q.size() != 5) begin
         n_bad++; $display("FAIL fill_beats: got %0d want 5", w_data_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (w_data_q[i] !== 32'hA0 + 32'(i) || w_last_q[i] !== (i == 4)) begin
               n_bad++; $display("FAIL fill_beat%0d: got %h/%b want %h/%b", i, w_data_q[i], w_last_q[i],
                                 32'hA0 + 32'(i), (i == 4));
            end
         end
      end
   endtask

   task automatic test_count_zero();
      start_fill(32'h5000, 32'h0, 32'd0, 32'h77);
      wait_done();
      n_cmp++;
      if (done_cnt !== 1) begin n_bad++; $display("FAIL zero_done: got %0d want 1", done_cnt); end
      n_cmp++;
      if (preq_q.size() != 4 || preq_q[0] !== 0 || preq_q[1] !== 4 || preq_q[2] !== 8 || preq_q[3] !== 12) begin
         n_bad++; $display("FAIL zero_param_addrs: got %p want 0,4,8,12", preq_q);
      end
      n_cmp++;
      if (aw_first !== -1 || w_data_q.size() != 0) begin
         n_bad++; $display("FAIL zero_no_aw: awvalid seen at %0d beats %0d want none", aw_first, w_data_q.size());
      end
   endtask

   task automatic test_4k_split();
      start_fill(32'h0FF8, 32'h0, 32'd6, 32'h10);
      wait_done();
      n_cmp++;
      if (done_cnt !== 1) begin n_bad++; $display("FAIL split_done: got %0d want 1", done_cnt); end
      n_cmp++;
      if (aw_addr_q.size() != 2 || aw_addr_q[0] !== 64'h0FF8 || aw_len_q[0] !== 8'd1
          || aw_addr_q[1] !== 64'h1000 || aw_len_q[1] !== 8'd3) begin
         n_bad++; $display("FAIL split_aw: got %p/%p want ff8/1,1000/3", aw_addr_q, aw_len_q);
      end
      n_cmp++;
      if (w_data_q.size() != 6) begin
         n_bad++; $display("FAIL split_beats: got %0d want 6", w_data_q.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (w_data_q[i] !== 32'h10 + 32'(i) || w_last_q[i] !== (i == 1 || i == 5)) begin
               n_bad++; $display("FAIL split_beat%0d: got %h/%b want %h/%b", i, w_data_q[i], w_last_q[i],
                                 32'h10 + 32'(i), (i == 1 || i == 5));
            end
         end
      end
   endtask

   task automatic test_error_abort();
      err_first = 1;
      start_fill(32'h2000, 32'h0, 32'd40, 32'h0);
      wait_done();
      repeat (10) @(negedge clk);
      err_first = 0;
      n_cmp++;
      if (done_cnt !== 1) begin n_bad++; $display("FAIL err_done: got %0d want 1", done_cnt); end
      n_cmp++;
      if (aw_addr_q.size() != 1 || aw_len_q[0] !== 8'd15) begin
         n_bad++; $display("FAIL err_single_aw: got %0d bursts len %p want 1 burst len 15",
                           aw_addr_q.size(), aw_len_q);
      end
      n_cmp++;
      if (w_data_q.size() != 16) begin
         n_bad++; $display("FAIL err_beats: got %0d want 16", w_data_q.size());
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] exp_addr [3];
      logic [7:0]  exp_len [3];
      exp_addr = '{64'h0FE0, 64'h1000, 64'h1040};
      exp_len  = '{8'd7, 8'd15, 8'd12};
      stall_en = 1;
      start_fill(32'h0FE0, 32'h0, 32'd37, 32'hFFFF_FFFE);
      wait_done();
      stall_en = 0;
      n_cmp++;
      if (done_cnt !== 1) begin n_bad++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
      n_cmp++;
      if (stab_err !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d changes want 0", stab_err); end
      n_cmp++;
      if (gostop_err !== 0) begin n_bad++; $display("FAIL bp_gostop: got %0d low cycles want 0", gostop_err); end
      n_cmp++;
      if (aw_addr_q.size() != 3) begin
         n_bad++; $display("FAIL bp_bursts: got %0d want 3", aw_addr_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (aw_addr_q[i] !== exp_addr[i] || aw_len_q[i] !== exp_len[i]) begin
               n_bad++; $display("FAIL bp_aw%0d: got %h/%0d want %h/%0d", i, aw_addr_q[i], aw_len_q[i],
                                 exp_addr[i], exp_len[i]);
            end
         end
      end
      n_cmp++;
      if (w_data_q.size() != 37) begin
         n_bad++; $display("FAIL bp_beats: got %0d want 37", w_data_q.size());
      end else begin
         int bad = 0;
         for (int i = 0; i < 37; i++)
            if (w_data_q[i] !== 32'hFFFF_FFFE + 32'(i) || w_last_q[i] !== (i == 7 || i == 23 || i == 36))
               bad++;
         n_cmp++;
         if (bad !== 0) begin n_bad++; $display("FAIL bp_data: got %0d bad beats want 0", bad); end
      end
   endtask

   task automatic test_reset_mid_burst();
      int n = 0;
      start_fill(32'h3000, 32'h0, 32'd8, 32'h55);
      while (w_data_q.size() < 3 && n < 200) begin @(posedge clk); #1; n++; end
      n_cmp++;
      if (w_data_q.size() !== 3 || wvalid !== 1'b1) begin
         n_bad++; $display("FAIL rst_mid_reach: got %0d beats wvalid %b want 3 beats wvalid 1",
                           w_data_q.size(), wvalid);
      end
      @(negedge clk); reset = 1;
      @(posedge clk); #1;
      n_cmp++;
      if ({awvalid, wvalid, bready, go_0Stop, done_0Ready} !== 5'b0) begin
         n_bad++; $display("FAIL rst_mid_outputs: got %b want 00000", {awvalid, wvalid, bready, go_0Stop, done_0Ready});
      end
      @(negedge clk); reset = 0;
      start_fill(32'h4000, 32'h0, 32'd3, 32'hC0);
      wait_done();
      n_cmp++;
      if (done_cnt !== 1) begin n_bad++; $display("FAIL rst_refill_done: got %0d want 1", done_cnt); end
      n_cmp++;
      if (aw_addr_q.size() != 1 || aw_addr_q[0] !== 64'h4000 || aw_len_q[0] !== 8'd2) begin
         n_bad++; $display("FAIL rst_refill_aw: got %p/%p want 4000/2", aw_addr_q, aw_len_q);
      end
      n_cmp++;
      if (w_data_q.size() != 3 || w_data_q[0] !== 32'hC0 || w_data_q[1] !== 32'hC1 || w_data_q[2] !== 32'hC2
          || w_last_q[2] !== 1'b1) begin
         n_bad++; $display("FAIL rst_refill_data: got %p want c0,c1,c2", w_data_q);
      end
   endtask

   initial begin
      reset = 1; go_0Ready = 0; done_0Stop = 0; paramaddr_0Stop = 0;
      paramdata_0Ready = 0; paramdata_0Data = 0;
      awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0; buser = 0;
      arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 0; ruser = 0;
      prm[0] = 0; prm[1] = 0; prm[2] = 0; prm[3] = 0;
      test_reset();
      test_fill_basic();
      test_count_zero();
      test_4k_split();
      test_error_abort();
      test_backpressure();
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
